// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Single-entry instruction fetch stage. It drives an address (pc) to a
// combinational instruction memory, registers the returned word into a one-deep
// output buffer (if_instr / if_pc / if_valid) and hands it to decode with a
// valid/ready handshake. Branch redirects replace pc and flush the buffer.
//
// Optional feature (macro FETCH_HALT_EN):
//   When defined, fetching the all-zero word stops the stage in HALTED instead
//   of delivering the word. The stage leaves HALTED only on rst or br_taken.
//   When undefined, the zero word is an ordinary instruction and halted is 0.
//
// Ports:
//   clk          in   1   clock, everything updates on the rising edge
//   rst          in   1   synchronous active-high reset
//   pc           out  3   address presented to instruction memory
//   instruction  in  16   memory read data for pc (combinational)
//   br_taken     in   1   redirect request, highest priority after rst
//   br_target    in   3   redirect address
//   id_ready     in   1   decode accepts if_instr this cycle
//   if_valid     out  1   if_instr / if_pc hold a fetched instruction
//   if_instr     out 16   fetched word: op[15:13] rs[12:10] rt[9:7] rd[6:4]
//                         func[3:0]
//   if_pc        out  3   address if_instr was fetched from
//   halted       out  1   high exactly while the FSM is in HALTED; this is
//                         also the observable copy of the FSM state
//
// Handshake: a transfer to decode happens on every rising edge where
// if_valid=1 and id_ready=1. While if_valid=1 and id_ready=0 the buffer and pc
// hold unchanged. if_valid never depends combinationally on id_ready.
// -----------------------------------------------------------------------------
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic [2:0]  pc,
  input  logic [15:0] instruction,
  input  logic        br_taken,
  input  logic [2:0]  br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [2:0]  if_pc,
  output logic        halted
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [15:0] if_instr_q, if_instr_d;
  logic [2:0]  if_pc_q, if_pc_d;

  // The buffer can take a new word when it is empty or being drained now.
  logic capture_ok;
  // High when the word at pc should stop the stage instead of being fetched.
  logic halt_word;

  assign capture_ok = !if_valid_q || id_ready;

`ifdef FETCH_HALT_EN
  assign halt_word = (instruction == 16'h0000);
`else
  assign halt_word = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;

    if (br_taken) begin
      // Redirect beats stall, capture and halt. The word at the old pc is
      // dropped; the target word is captured on the following edge.
      pc_d       = br_target;
      if_valid_d = 1'b0;
      state_d    = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (capture_ok) begin
            if (halt_word) begin
              // capture_ok already implies the buffer is empty or draining,
              // so it is always empty after this edge.
              state_d    = HALTED;
              if_valid_d = 1'b0;
            end else begin
              if_instr_d = instruction;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
              pc_d       = pc_q + 3'd1;  // 3-bit add wraps 7 -> 0
            end
          end
        end
        HALTED: begin
          // No new fetches; a word still in the buffer may finish its
          // handshake.
          if (if_valid_q && id_ready) begin
            if_valid_d = 1'b0;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= 3'd0;
      if_valid_q <= 1'b0;
      if_instr_q <= 16'h0000;
      if_pc_q    <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign pc       = pc_q;
  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

`ifdef FETCH_HALT_EN
  assign halted = (state_q == HALTED);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Bench for instr_fetch. Drives a small combinational memory model and checks
// the DUT against a directed vector table, hand-written corner sequences and a
// randomized run compared with a cycle model of the fetch rules. Delivered
// words are also checked through an expected queue of {pc, word} pairs.
// Works with and without FETCH_HALT_EN defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  pc;
  logic [15:0] instruction;
  logic        br_taken = 1'b0;
  logic [2:0]  br_target = 3'd0;
  logic        id_ready = 1'b0;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [2:0]  if_pc;
  logic        halted;

  always #5 clk = ~clk;

  logic [15:0] mem [8];
  assign instruction = mem[pc];

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .instruction (instruction),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .halted      (halted)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [18:0] exp_q[$];   // {pc, word} in delivery order

  // reference model of the architectural state
  logic [2:0]  m_pc    = 3'd0;
  logic        m_valid = 1'b0;
  logic [15:0] m_instr = 16'h0;
  logic [2:0]  m_ifpc  = 3'd0;
  logic        m_halt  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fill_mem_nonzero();
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i * 16'h0111) + 16'h0001;
  endtask

  // ---------------- driver + model step ----------------
  // Drive one cycle of inputs, advance the model by the fetch rules, then
  // compare DUT outputs after the edge.
  task automatic step(input bit r, input bit b, input logic [2:0] t,
                      input bit rdy);
    logic [15:0] word;
    logic [18:0] got;
    rst = r; br_taken = b; br_target = t; id_ready = rdy;
    #1;
    // delivery to decode happens on this edge
    if (!r && if_valid === 1'b1 && rdy) begin
      got = {if_pc, if_instr};
      if (exp_q.size() == 0) chk("sb_unexpected_delivery", {13'd0, got}, 32'h7FFFF);
      else chk("sb_delivered_word", {13'd0, got}, {13'd0, exp_q.pop_front()});
    end
    word = mem[m_pc];
    if (r) begin
      m_pc = 0; m_valid = 0; m_instr = 0; m_ifpc = 0; m_halt = 0;
      exp_q.delete();
    end else if (b) begin
      m_pc = t; m_valid = 0; m_halt = 0;
      exp_q.delete();
    end else if (m_halt) begin
      if (m_valid && rdy) m_valid = 0;
    end else if (!m_valid || rdy) begin
      if (HALT_EN && word == 16'h0000) begin
        m_halt = 1; m_valid = 0;
      end else begin
        m_instr = word; m_ifpc = m_pc; m_valid = 1;
        m_pc = 3'((m_pc + 1) % 8);
        exp_q.push_back({m_ifpc, m_instr});
      end
    end
    @(posedge clk);
    #1;
    chk("m_pc", {29'd0, pc}, {29'd0, m_pc});
    chk("m_if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
    if (m_valid || r) begin
      chk("m_if_pc", {29'd0, if_pc}, {29'd0, m_ifpc});
      chk("m_if_instr", {16'd0, if_instr}, {16'd0, m_instr});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit         r;
    bit         b;
    logic [2:0] t;
    bit         rdy;
    logic [2:0] e_pc;
    bit         e_v;
    logic [2:0] e_ifpc;
  } vec_t;

  vec_t vecs [19];

  initial begin
    // reset, straight line, stall, redirects, wrap, redirect to current pc
    vecs[0]  = '{1, 0, 3'd0, 1, 3'd0, 0, 3'd0};
    vecs[1]  = '{0, 0, 3'd0, 1, 3'd1, 1, 3'd0};
    vecs[2]  = '{0, 0, 3'd0, 1, 3'd2, 1, 3'd1};
    vecs[3]  = '{0, 0, 3'd0, 1, 3'd3, 1, 3'd2};
    vecs[4]  = '{0, 0, 3'd0, 0, 3'd3, 1, 3'd2};
    vecs[5]  = '{0, 0, 3'd0, 0, 3'd3, 1, 3'd2};
    vecs[6]  = '{0, 0, 3'd0, 0, 3'd3, 1, 3'd2};
    vecs[7]  = '{0, 0, 3'd0, 1, 3'd4, 1, 3'd3};
    vecs[8]  = '{0, 0, 3'd0, 1, 3'd5, 1, 3'd4};
    vecs[9]  = '{0, 1, 3'd1, 1, 3'd1, 0, 3'd0};
    vecs[10] = '{0, 0, 3'd0, 1, 3'd2, 1, 3'd1};
    vecs[11] = '{0, 1, 3'd5, 0, 3'd5, 0, 3'd0};
    vecs[12] = '{0, 0, 3'd0, 1, 3'd6, 1, 3'd5};
    vecs[13] = '{0, 0, 3'd0, 1, 3'd7, 1, 3'd6};
    vecs[14] = '{0, 0, 3'd0, 1, 3'd0, 1, 3'd7};
    vecs[15] = '{0, 0, 3'd0, 1, 3'd1, 1, 3'd0};
    vecs[16] = '{0, 1, 3'd1, 1, 3'd1, 0, 3'd0};
    vecs[17] = '{0, 0, 3'd0, 1, 3'd2, 1, 3'd1};
    vecs[18] = '{0, 0, 3'd0, 0, 3'd2, 1, 3'd1};
  end

  // ---------------- test sequence ----------------
  initial begin
    fill_mem_nonzero();
    #0;

    // table-driven directed vectors
    for (int i = 0; i < 19; i++) begin
      step(vecs[i].r, vecs[i].b, vecs[i].t, vecs[i].rdy);
      chk($sformatf("vec%0d_pc", i), {29'd0, pc}, {29'd0, vecs[i].e_pc});
      chk($sformatf("vec%0d_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].e_v});
      if (vecs[i].e_v) begin
        chk($sformatf("vec%0d_if_pc", i), {29'd0, if_pc}, {29'd0, vecs[i].e_ifpc});
        chk($sformatf("vec%0d_if_instr", i), {16'd0, if_instr},
            {16'd0, mem[vecs[i].e_ifpc]});
      end
      if (vecs[i].r) chk("vec_reset_instr", {16'd0, if_instr}, 32'h0);
    end

    // reset mid-run while if_pc=3 and valid
    step(1, 0, 3'd0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 3'd0, 1);
    chk("rst_pre_if_pc", {29'd0, if_pc}, 32'd3);
    step(1, 1, 3'd6, 0);
    chk("rst_pc", {29'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_instr", {16'd0, if_instr}, 32'h0);
    chk("rst_if_pc", {29'd0, if_pc}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    step(0, 0, 3'd0, 1);
    chk("rst_release_if_pc", {29'd0, if_pc}, 32'd0);
    chk("rst_release_valid", {31'd0, if_valid}, 32'd1);

    // zero word at address 5
    mem[5] = 16'h0000;
    step(1, 0, 3'd0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 3'd0, 1);
    chk("zero_pre_if_pc", {29'd0, if_pc}, 32'd4);
    step(0, 0, 3'd0, 1);
`ifdef FETCH_HALT_EN
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_pc", {29'd0, pc}, 32'd5);
    chk("halt_valid", {31'd0, if_valid}, 32'd0);
    step(0, 0, 3'd0, 1);
    chk("halt_hold_pc", {29'd0, pc}, 32'd5);
    chk("halt_hold_halted", {31'd0, halted}, 32'd1);
    step(0, 1, 3'd0, 1);
    chk("halt_exit_halted", {31'd0, halted}, 32'd0);
    chk("halt_exit_pc", {29'd0, pc}, 32'd0);
    step(0, 0, 3'd0, 1);
    chk("halt_exit_if_pc", {29'd0, if_pc}, 32'd0);
    chk("halt_exit_valid", {31'd0, if_valid}, 32'd1);
`else
    chk("zero_if_pc", {29'd0, if_pc}, 32'd5);
    chk("zero_if_instr", {16'd0, if_instr}, 32'h0);
    chk("zero_valid", {31'd0, if_valid}, 32'd1);
    chk("zero_halted", {31'd0, halted}, 32'd0);
    chk("zero_pc", {29'd0, pc}, 32'd6);
`endif

    // randomized run against the model
    step(1, 0, 3'd0, 1);
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) begin
        for (int k = 0; k < 8; k++)
          mem[k] = ($urandom_range(0, 4) == 0) ? 16'h0000
                                                : 16'($urandom_range(1, 65535));
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
           3'($urandom_range(0, 7)), $urandom_range(0, 9) < 7);
    end

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
